// File: rtl/apb_fifo_slave_pkg.sv
// ---------------------------------------------------------------------------
// apb_fifo_slave_pkg
// Shared constants for the APB FIFO completer.
//   - reg_sel_t : 2-bit register select, taken from PADDR[3:2]
//   - *_OFS     : register select codes (byte offsets 0x0/0x4/0x8/0xC)
//   - FSR_* / FCR_* : bit positions inside the status and control registers
// ---------------------------------------------------------------------------
package apb_fifo_slave_pkg;

   typedef logic [1:0] reg_sel_t;

   // Word-select codes; byte offset = code * 4.
   localparam reg_sel_t FSR_OFS = 2'd0;
   localparam reg_sel_t FWD_OFS = 2'd1;
   localparam reg_sel_t FRD_OFS = 2'd2;
   localparam reg_sel_t FCR_OFS = 2'd3;

   // FSR layout
   localparam int FSR_EMPTY   = 0;
   localparam int FSR_FULL    = 1;
   localparam int FSR_OVF     = 2;
   localparam int FSR_UNF     = 3;
   localparam int FSR_CNT_LSB = 8;
   localparam int FSR_CNT_W   = 8;

   // FCR layout
   localparam int FCR_CLEAR   = 0;
   localparam int FCR_IE      = 1;

endpackage

// File: rtl/apb_fifo_slave_fifo_core.sv
// ---------------------------------------------------------------------------
// fifo_core
// Synchronous DEPTH x 32 FIFO with a combinational head output.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (pointers/count only)
//   push, pop    : ignored when full / empty respectively
//   clear        : synchronous flush of pointers and count, overrides push/pop
//   wdata        : data pushed on push
//   rdata        : current head entry (combinational, undefined when empty)
//   empty, full  : status
//   count        : number of stored entries, log2(DEPTH)+1 bits
// Storage contents are intentionally not reset.
// ---------------------------------------------------------------------------
module fifo_core #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_push = push & ~full & ~clear;
   assign do_pop  = pop & ~empty & ~clear;
   assign rdata   = mem[rd_ptr];

   // Pointers are exactly AW bits wide, so they wrap at DEPTH on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/apb_fifo_slave.sv
// ---------------------------------------------------------------------------
// apb_fifo_slave
// APB completer exposing a DEPTH-entry 32-bit FIFO through four registers:
//   0x0 FSR  status: empty, full, overflow(W1C), underflow(W1C), count[15:8]
//   0x4 FWD  write pushes, reads 0
//   0x8 FRD  read pops head, writes ignored
//   0xC FCR  [0] clear (write-1 action, reads 0), [1] ie
// Ports:
//   PCLK, PRESET          : clock, asynchronous active-high reset
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA : APB request
//   PRDATA, PREADY        : APB response
//   PSLVERR               : only when APB_FIFO_SLAVE_PSLVERR_EN is defined
//   irq                   : level interrupt, FCR.ie & ~empty
// Build option: `define APB_FIFO_SLAVE_PSLVERR_EN adds PSLVERR and rejects
// accesses with PADDR[ADDR_W-1:4] != 0; otherwise offsets alias by PADDR[3:2].
//
// Handshake: a transfer is SETUP (PSEL & ~PENABLE) followed by one or more
// ACCESS cycles (PSEL & PENABLE); it completes on the clock edge where
// PSEL & PENABLE & PREADY is high, and every side effect happens on that edge
// only. PREADY rises after WAIT_STATES stalled ACCESS cycles.
// ---------------------------------------------------------------------------
module apb_fifo_slave
   import apb_fifo_slave_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int WAIT_STATES = 0,
   parameter int ADDR_W      = 4
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
`ifdef APB_FIFO_SLAVE_PSLVERR_EN
   output logic              PSLVERR,
`endif
   output logic              irq
);

   localparam int          CW = $clog2(DEPTH) + 1;
   localparam logic [3:0]  WS = WAIT_STATES[3:0];

   logic [3:0]    wait_cnt;
   logic          access;
   logic          done;
   reg_sel_t      sel;
   logic          oor;
   logic          hit;

   logic          wr_fsr, wr_fwd, wr_fcr, rd_frd;
   logic          ovf_q, unf_q, ie_q;

   logic [31:0]   head;
   logic          empty, full;
   logic [CW-1:0] count;
   logic          fifo_push, fifo_pop, fifo_clear;

   logic [31:0]          rd_word;
   logic [FSR_CNT_W-1:0] cnt_ext;
   logic                 unused_paddr;

   // Gating with PRESET keeps the response idle while reset is held, even if
   // the bus is parked in ACCESS.
   assign access = PSEL & PENABLE & ~PRESET;
   assign PREADY = access & (wait_cnt == WS);
   assign done   = PREADY;
   assign sel    = PADDR[3:2];
   assign unused_paddr = ^PADDR;

`ifdef APB_FIFO_SLAVE_PSLVERR_EN
   if (ADDR_W > 4) begin : g_oor
      assign oor = |PADDR[ADDR_W-1:4];
   end else begin : g_no_oor
      assign oor = 1'b0;
   end
`else
   assign oor = 1'b0;
`endif

   assign hit    = ~oor;
   assign wr_fsr = done &  PWRITE & hit & (sel == FSR_OFS);
   assign wr_fwd = done &  PWRITE & hit & (sel == FWD_OFS);
   assign wr_fcr = done &  PWRITE & hit & (sel == FCR_OFS);
   assign rd_frd = done & ~PWRITE & hit & (sel == FRD_OFS);

   // Counter runs only while stalled in ACCESS; SETUP, completion, idle and a
   // dropped PSEL all return it to zero.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET)                wait_cnt <= '0;
      else if (access & ~PREADY) wait_cnt <= wait_cnt + 1'b1;
      else                       wait_cnt <= '0;
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         ie_q  <= 1'b0;
      end else begin
         ovf_q <= (ovf_q & ~(wr_fsr & PWDATA[FSR_OVF])) | (wr_fwd & full);
         unf_q <= (unf_q & ~(wr_fsr & PWDATA[FSR_UNF])) | (rd_frd & empty);
         if (wr_fcr) ie_q <= PWDATA[FCR_IE];
      end
   end

   assign fifo_push  = wr_fwd;
   assign fifo_pop   = rd_frd;
   assign fifo_clear = wr_fcr & PWDATA[FCR_CLEAR];

   fifo_core #(.DEPTH(DEPTH)) u_fifo_core (
      .clk   (PCLK),
      .rst   (PRESET),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .clear (fifo_clear),
      .wdata (PWDATA),
      .rdata (head),
      .empty (empty),
      .full  (full),
      .count (count)
   );

   always_comb begin
      rd_word          = '0;
      cnt_ext          = '0;
      cnt_ext[CW-1:0]  = count;
      case (sel)
         FSR_OFS: begin
            rd_word[FSR_EMPTY] = empty;
            rd_word[FSR_FULL]  = full;
            rd_word[FSR_OVF]   = ovf_q;
            rd_word[FSR_UNF]   = unf_q;
            rd_word[FSR_CNT_LSB +: FSR_CNT_W] = cnt_ext;
         end
         FRD_OFS: if (!empty) rd_word = head;
         FCR_OFS: rd_word[FCR_IE] = ie_q;
         default: rd_word = '0;
      endcase
   end

   assign PRDATA = (access & ~PWRITE & hit) ? rd_word : '0;

`ifdef APB_FIFO_SLAVE_PSLVERR_EN
   assign PSLVERR = done & (oor
                          | (PWRITE  & (sel == FWD_OFS) & full)
                          | (~PWRITE & (sel == FRD_OFS) & empty));
`endif

   assign irq = ie_q & ~empty;

endmodule

// File: tb/tb_apb_fifo_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_fifo_slave
// Directed bench for apb_fifo_slave. Two instances share the APB bus on
// separate PSEL slots: slot 0 (DEPTH 8, no wait states, ADDR_W 4) and
// slot 1 (DEPTH 8, 3 wait states, ADDR_W 8).
// ---------------------------------------------------------------------------
module tb_apb_fifo_slave;

   logic        PCLK;
   logic        PRESET;
   logic [7:0]  PADDR;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic        psel0, psel1;

   logic [31:0] prdata0, prdata1;
   logic        pready0, pready1;
   logic        irq0, irq1;
`ifdef APB_FIFO_SLAVE_PSLVERR_EN
   logic        pslverr0, pslverr1;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   logic        setup_ready;
   int          last_waits;
   logic        early_irq;
   logic        last_err;
   logic [31:0] rdat;

   // ---------------- clock / reset ----------------
   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // ---------------- DUTs ----------------
   apb_fifo_slave #(.DEPTH(8), .WAIT_STATES(0), .ADDR_W(4)) u_dut0 (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .PADDR   (PADDR[3:0]),
      .PSEL    (psel0),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PWDATA  (PWDATA),
      .PRDATA  (prdata0),
      .PREADY  (pready0),
`ifdef APB_FIFO_SLAVE_PSLVERR_EN
      .PSLVERR (pslverr0),
`endif
      .irq     (irq0)
   );

   apb_fifo_slave #(.DEPTH(8), .WAIT_STATES(3), .ADDR_W(8)) u_dut1 (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .PADDR   (PADDR),
      .PSEL    (psel1),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PWDATA  (PWDATA),
      .PRDATA  (prdata1),
      .PREADY  (pready1),
`ifdef APB_FIFO_SLAVE_PSLVERR_EN
      .PSLVERR (pslverr1),
`endif
      .irq     (irq1)
   );

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic cur_ready(input int slot);
      return (slot == 0) ? pready0 : pready1;
   endfunction

   function automatic logic cur_irq(input int slot);
      return (slot == 0) ? irq0 : irq1;
   endfunction

   function automatic logic [31:0] cur_rdata(input int slot);
      return (slot == 0) ? prdata0 : prdata1;
   endfunction

   function automatic logic cur_err(input int slot);
`ifdef APB_FIFO_SLAVE_PSLVERR_EN
      return (slot == 0) ? pslverr0 : pslverr1;
`else
      return (slot < 0);
`endif
   endfunction

   // ---------------- driver ----------------
   // Inputs change on the falling edge; outputs are sampled 1ns later.
   task automatic apb_xfer(input int slot, input logic wr, input logic [7:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata);
      @(negedge PCLK);
      PADDR   = addr;
      PWRITE  = wr;
      PWDATA  = wdata;
      PENABLE = 1'b0;
      psel0   = (slot == 0);
      psel1   = (slot == 1);
      #1 setup_ready = cur_ready(slot);
      @(negedge PCLK);
      PENABLE = 1'b1;
      #1;
      last_waits = 0;
      early_irq  = 1'b0;
      while (!cur_ready(slot) && last_waits < 40) begin
         if (cur_irq(slot)) early_irq = 1'b1;
         @(negedge PCLK);
         #1;
         last_waits++;
      end
      check_val("pready_seen", {31'b0, cur_ready(slot)}, 32'd1);
      rdata    = cur_rdata(slot);
      last_err = cur_err(slot);
      @(posedge PCLK);
      #1;
      psel0   = 1'b0;
      psel1   = 1'b0;
      PENABLE = 1'b0;
   endtask

   task automatic apb_wr(input int slot, input logic [7:0] addr, input logic [31:0] data);
      logic [31:0] dummy;
      apb_xfer(slot, 1'b1, addr, data, dummy);
   endtask

   task automatic apb_rd(input int slot, input logic [7:0] addr, output logic [31:0] data);
      apb_xfer(slot, 1'b0, addr, 32'h0, data);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      PRESET  = 1'b1;
      PADDR   = '0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PWDATA  = '0;
      psel0   = 1'b0;
      psel1   = 1'b0;
      repeat (3) @(negedge PCLK);
      PRESET = 1'b0;
      #1;

      // 1. reset state and first status read
      check_val("rst_pready", {31'b0, pready0}, 32'd0);
      check_val("rst_prdata", prdata0, 32'h0);
      check_val("rst_irq", {31'b0, irq0}, 32'd0);
      apb_rd(0, 8'h0, rdat);
      check_val("fsr_after_reset", rdat, 32'h0000_0001);
      check_val("setup_pready_low", {31'b0, setup_ready}, 32'd0);
      check_val("ws0_waits", last_waits, 32'd0);

      // 2. fill to DEPTH
      for (int i = 1; i <= 8; i++) begin
         apb_wr(0, 8'h4, 32'hA5A5_0000 + i);
         exp_q.push_back(32'hA5A5_0000 + i);
      end
      apb_rd(0, 8'h0, rdat);
      check_val("fsr_full", rdat, 32'h0000_0802);
      apb_rd(0, 8'h4, rdat);
      check_val("fwd_reads_zero", rdat, 32'h0);

      // 3. overflow and W1C
      apb_wr(0, 8'h4, 32'hDEAD_BEEF);
`ifdef APB_FIFO_SLAVE_PSLVERR_EN
      check_val("pslverr_ovf", {31'b0, last_err}, 32'd1);
`endif
      apb_rd(0, 8'h0, rdat);
      check_val("fsr_overflow", rdat, 32'h0000_0806);
      apb_wr(0, 8'h0, 32'h4);
      apb_rd(0, 8'h0, rdat);
      check_val("fsr_ovf_cleared", rdat, 32'h0000_0802);

      // drain in order
      for (int i = 0; i < 8; i++) begin
         apb_rd(0, 8'h8, rdat);
         check_val("frd_data", rdat, exp_q.pop_front());
`ifdef APB_FIFO_SLAVE_PSLVERR_EN
         check_val("pslverr_pop_ok", {31'b0, last_err}, 32'd0);
`endif
      end
      apb_rd(0, 8'h0, rdat);
      check_val("fsr_drained", rdat, 32'h0000_0001);

      // 4. underflow
      apb_rd(0, 8'h8, rdat);
      check_val("frd_empty_data", rdat, 32'h0);
`ifdef APB_FIFO_SLAVE_PSLVERR_EN
      check_val("pslverr_unf", {31'b0, last_err}, 32'd1);
`endif
      apb_rd(0, 8'h0, rdat);
      check_val("fsr_underflow", rdat, 32'h0000_0009);
      apb_wr(0, 8'h0, 32'h8);
      apb_rd(0, 8'h0, rdat);
      check_val("fsr_unf_cleared", rdat, 32'h0000_0001);
      apb_wr(0, 8'h4, 32'h0000_1234);
      exp_q.push_back(32'h0000_1234);
      apb_wr(0, 8'h8, 32'hFFFF_FFFF);
      apb_rd(0, 8'h0, rdat);
      check_val("frd_write_ignored", rdat, 32'h0000_0100);
      apb_rd(0, 8'h8, rdat);
      check_val("frd_after_unf", rdat, exp_q.pop_front());

      // 5. wait states on slot 1
      apb_wr(1, 8'hC, 32'h2);
      check_val("ws3_waits_fcr", last_waits, 32'd3);
      apb_wr(1, 8'h4, 32'h0000_0077);
      check_val("ws3_waits_push", last_waits, 32'd3);
      check_val("ws3_no_early_push", {31'b0, early_irq}, 32'd0);
      check_val("ws3_irq_after_push", {31'b0, irq1}, 32'd1);
      apb_rd(1, 8'h8, rdat);
      check_val("ws3_pop_data", rdat, 32'h0000_0077);
      check_val("ws3_waits_pop", last_waits, 32'd3);
      check_val("ws3_irq_cleared", {31'b0, irq1}, 32'd0);
      apb_rd(1, 8'h10, rdat);
`ifdef APB_FIFO_SLAVE_PSLVERR_EN
      check_val("oor_data", rdat, 32'h0);
      check_val("oor_pslverr", {31'b0, last_err}, 32'd1);
`else
      check_val("alias_fsr", rdat, 32'h0000_0001);
`endif

      // 6. interrupt, clear, reset mid-transfer
      apb_wr(0, 8'hC, 32'h2);
      apb_rd(0, 8'hC, rdat);
      check_val("fcr_ie_read", rdat, 32'h2);
      check_val("irq_empty_ie", {31'b0, irq0}, 32'd0);
      apb_wr(0, 8'h4, 32'h0000_0055);
      check_val("irq_set", {31'b0, irq0}, 32'd1);
      apb_wr(0, 8'hC, 32'h3);
      check_val("irq_after_clear", {31'b0, irq0}, 32'd0);
      apb_rd(0, 8'h0, rdat);
      check_val("fsr_after_clear", rdat, 32'h0000_0001);
      apb_rd(0, 8'hC, rdat);
      check_val("fcr_clear_reads0", rdat, 32'h2);

      @(negedge PCLK);
      PADDR = 8'h4; PWRITE = 1'b1; PWDATA = 32'h0BAD_0BAD; PENABLE = 1'b0; psel0 = 1'b1;
      @(negedge PCLK);
      PENABLE = 1'b1;
      #1 PRESET = 1'b1;
      #1 check_val("pready_in_reset", {31'b0, pready0}, 32'd0);
      @(negedge PCLK);
      psel0 = 1'b0; PENABLE = 1'b0;
      @(negedge PCLK);
      PRESET = 1'b0;
      apb_rd(0, 8'h0, rdat);
      check_val("fsr_after_midreset", rdat, 32'h0000_0001);
      apb_rd(0, 8'hC, rdat);
      check_val("fcr_after_midreset", rdat, 32'h0);
      check_val("irq_after_midreset", {31'b0, irq0}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
